psr_cond_unit: RTL

Processor status register and condition evaluator for the 16-bit CPU. It captures the 5-bit flag vector produced by the ALU and holds it as the architectural PSR. It answers branch/jump condition queries from the control FSM through a one-deep valid/ready response pipeline. Placement: on the datapath between the ALU flag outputs and the PC-update logic.

---
 rtl/psr_cond_if.sv | 28 ++
 rtl/psr_cond_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/psr_cond_if.sv
// Condition query/response handshake bundle for psr_cond_unit.
// master: the requester (control FSM); slave: psr_cond_unit.
interface psr_cond_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_cond;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_taken;

    modport master (
        output req_valid,
        output req_cond,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_taken
    );

    modport slave (
        input  req_valid,
        input  req_cond,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_taken
    );
endinterface

// File: rtl/psr_cond_unit.sv
// Processor status register and branch condition evaluator.
// Holds the 5-bit ALU flag vector (C, L, F, Z, N) and answers condition
// queries through a one-deep valid/ready response register.
// Optional macro PSR_FWD_EN: queries accepted in the same cycle as a flag
// write see the new flag values; otherwise queries see the registered PSR.
module psr_cond_unit #(
    parameter int FLAG_W = 5,
    parameter int COND_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [FLAG_W-1:0] flags_we,
    output logic [FLAG_W-1:0] psr,
    psr_cond_if.slave         bus
);

    // Flag bit positions
    localparam int B_C = 0;
    localparam int B_L = 1;
    localparam int B_F = 2;
    localparam int B_Z = 3;
    localparam int B_N = 4;

    logic [FLAG_W-1:0] psr_q;
    logic [FLAG_W-1:0] psr_d;
    logic [FLAG_W-1:0] eff_flags;
    logic [COND_W-1:0] cond;
    logic              resp_valid_q;
    logic              resp_valid_d;
    logic              resp_taken_q;
    logic              resp_taken_d;
    logic              accept;

    // Even codes select a base predicate; odd codes are its inverse, so
    // the evaluator decodes cond[3:1] and conditionally flips with cond[0].
    function automatic logic eval_cond(input logic [COND_W-1:0] c,
                                       input logic [FLAG_W-1:0] e);
        logic base;
        base = 1'b0;
        case (c[3:1])
            3'd0:    base = e[B_Z];
            3'd1:    base = e[B_C];
            3'd2:    base = e[B_L];
            3'd3:    base = e[B_N];
            3'd4:    base = e[B_F];
            3'd5:    base = !e[B_N] && !e[B_Z];
            3'd6:    base = !e[B_L] && !e[B_Z];
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    // Per-bit masked PSR next state: only enabled bits take the ALU value.
    genvar gi;
    generate
        for (gi = 0; gi < FLAG_W; gi++) begin : g_psr_bit
            assign psr_d[gi] = flags_we[gi] ? flags_in[gi] : psr_q[gi];
        end
    endgenerate

    // Flags seen by a query accepted this cycle.
`ifdef PSR_FWD_EN
    assign eff_flags = psr_d;
`else
    assign eff_flags = psr_q;
`endif

    assign cond          = bus.req_cond;
    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Response register next state: load on accept, drain on consume, else hold.
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_taken_d = resp_taken_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_taken_d = eval_cond(cond, eff_flags);
        end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // PSR and response state registers; reset discards any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
        end else begin
            psr_q        <= psr_d;
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
        end
    end

    assign psr            = psr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_taken = resp_taken_q;

endmodule
